// File: rtl/move_input_conditioner.sv
// Input stage for the game block: synchronises and debounces the push-button and
// the nine cell-select switches, and turns each accepted press into one move request.
module move_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic [8:0] switches,
  output logic       move_valid,
  output logic       move_err,
  output logic [3:0] move_cell,
  output logic       btn_level,
  output logic [8:0] sw_level
);

  localparam int unsigned N_IN = 10;
  localparam int unsigned N_SW = 9;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] CELL_NONE = 4'hF;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  logic [N_IN-1:0]  sync1;
  logic [N_IN-1:0]  sync2;
  logic [N_IN-1:0]  stable;
  logic [CNT_W-1:0] cnt [N_IN];

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic       valid_nxt;
  logic       err_nxt;
  logic [3:0] cell_nxt;
  logic [3:0] ones_c;
  logic [3:0] idx_c;

  // Two-flop synchroniser; bit 9 carries the button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {button, switches};
      sync2 <= sync1;
    end
  end

  // Per-input debounce: a change is taken only after an unbroken run of disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign btn_level = stable[N_IN-1];
  assign sw_level  = stable[N_SW-1:0];

  // Population count and highest set index of the debounced switches.
  always_comb begin
    ones_c = '0;
    idx_c  = '0;
    for (int i = 0; i < N_SW; i++) begin
      if (sw_level[i]) begin
        ones_c = ones_c + 4'd1;
        idx_c  = 4'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      move_valid <= 1'b0;
      move_err   <= 1'b0;
      move_cell  <= CELL_NONE;
    end else begin
      state      <= state_nxt;
      move_valid <= valid_nxt;
      move_err   <= err_nxt;
      move_cell  <= cell_nxt;
    end
  end

  // Press FSM: one request on the first debounced-high cycle, then wait for release.
  always_comb begin
    state_nxt = state;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    cell_nxt  = move_cell;
    case (state)
      IDLE: begin
        if (btn_level) begin
          state_nxt = HELD;
          if (ones_c == 4'd1) begin
            valid_nxt = 1'b1;
            cell_nxt  = idx_c;
          end else begin
            err_nxt  = 1'b1;
            cell_nxt = CELL_NONE;
          end
        end
      end
      HELD: begin
        if (!btn_level) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_move_input_conditioner.sv
// Bench for move_input_conditioner: directed scenarios with literal checks plus random
// stimulus compared every cycle against a sliding-window behavioural model.
module tb_move_input_conditioner;

  localparam int unsigned D     = 4;
  localparam int unsigned CNT_W = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic [8:0] switches;
  logic       move_valid;
  logic       move_err;
  logic [3:0] move_cell;
  logic       btn_level;
  logic [8:0] sw_level;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  move_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .button    (button),
    .switches  (switches),
    .move_valid(move_valid),
    .move_err  (move_err),
    .move_cell (move_cell),
    .btn_level (btn_level),
    .sw_level  (sw_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: raw samples history; a level flips when the last D synchronised samples all disagree.
  logic [9:0] hist [D+2];
  logic [9:0] m_q;
  bit         m_held;
  logic       m_valid;
  logic       m_err;
  logic [3:0] m_cell;

  always @(posedge clk) begin
    logic [9:0] qold;
    logic [9:0] differ;
    started = 1'b1;
    qold = m_q;
    if (rst) begin
      for (int k = 0; k < D + 2; k++) hist[k] = '0;
      m_q     = '0;
      m_held  = 1'b0;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_cell  = 4'hF;
    end else begin
      for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = {button, switches};
      differ = '1;
      for (int k = 2; k <= D + 1; k++) differ = differ & (hist[k] ^ qold);
      m_q = qold ^ differ;
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (!m_held && qold[9]) begin
        m_held = 1'b1;
        if ($countones(qold[8:0]) == 1) begin
          m_valid = 1'b1;
          for (int i = 0; i < 9; i++) if (qold[i]) m_cell = 4'(i);
        end else begin
          m_err  = 1'b1;
          m_cell = 4'hF;
        end
      end else if (m_held && !qold[9]) begin
        m_held = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_valid", 32'(move_valid), 32'(m_valid));
      chk("model_err",   32'(move_err),   32'(m_err));
      chk("model_cell",  32'(move_cell),  32'(m_cell));
      chk("model_btn",   32'(btn_level),  32'(m_q[9]));
      chk("model_sw",    32'(sw_level),   32'(m_q[8:0]));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic count_strobes(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      tick(1);
      if (move_valid || move_err) cnt++;
    end
  endtask

  initial begin
    int s;
    logic [8:0] seen;
    int j;
    rst = 1'b1;
    button = 1'b0;
    switches = '0;
    tick(3);
    chk("rst_valid", 32'(move_valid), 32'd0);
    chk("rst_err",   32'(move_err),   32'd0);
    chk("rst_cell",  32'(move_cell),  32'hF);
    chk("rst_btn",   32'(btn_level),  32'd0);
    chk("rst_sw",    32'(sw_level),   32'd0);
    rst = 1'b0;

    // Single legal move on cell 4
    switches = 9'b000010000;
    tick(10);
    chk("t1_sw", 32'(sw_level), 32'h010);
    button = 1'b1;
    tick(6);
    chk("t1_early", 32'(move_valid), 32'd0);
    chk("t1_btn",   32'(btn_level),  32'd1);
    tick(1);
    chk("t1_valid", 32'(move_valid), 32'd1);
    chk("t1_cell",  32'(move_cell),  32'd4);
    chk("t1_err",   32'(move_err),   32'd0);
    count_strobes(30, s);
    chk("t1_norepeat", 32'(s), 32'd0);
    chk("t1_hold_cell", 32'(move_cell), 32'd4);
    button = 1'b0;
    tick(10);

    // Error: no switch on
    switches = '0;
    tick(10);
    button = 1'b1;
    tick(7);
    chk("e0_err",   32'(move_err),   32'd1);
    chk("e0_valid", 32'(move_valid), 32'd0);
    chk("e0_cell",  32'(move_cell),  32'hF);
    button = 1'b0;
    tick(10);

    // Error: two switches on
    switches = 9'b100000001;
    tick(10);
    button = 1'b1;
    tick(7);
    chk("e2_err",   32'(move_err),   32'd1);
    chk("e2_valid", 32'(move_valid), 32'd0);
    button = 1'b0;
    tick(10);

    // Bounce rejection
    switches = 9'b000000100;
    tick(10);
    foreach (hist[k]) begin
      if (k < 5) begin
        button = (k % 2 == 0);
        tick(1);
      end
    end
    button = 1'b1;
    tick(4);
    chk("b_btn_low",  32'(btn_level), 32'd0);
    tick(1);
    chk("b_btn_high", 32'(btn_level), 32'd1);
    count_strobes(20, s);
    chk("b_once", 32'(s), 32'd1);
    chk("b_cell", 32'(move_cell), 32'd2);
    button = 1'b0;
    tick(10);

    // Hold then re-press
    switches = 9'b000000001;
    tick(10);
    button = 1'b1;
    count_strobes(100, s);
    chk("h_once", 32'(s), 32'd1);
    chk("h_cell", 32'(move_cell), 32'd0);
    button = 1'b0;
    tick(8);
    switches = 9'b100000000;
    tick(10);
    button = 1'b1;
    tick(7);
    chk("h2_valid", 32'(move_valid), 32'd1);
    chk("h2_cell",  32'(move_cell),  32'd8);
    button = 1'b0;
    tick(10);

    // Short switch glitch is rejected
    switches = '0;
    tick(10);
    switches = 9'b000001000;
    seen = '0;
    for (int k = 0; k < 15; k++) begin
      if (k == 3) switches = '0;
      tick(1);
      seen = seen | sw_level;
    end
    chk("g_sw", 32'(seen), 32'd0);
    button = 1'b1;
    tick(7);
    chk("g_err", 32'(move_err), 32'd1);
    button = 1'b0;
    tick(10);

    // Reset in the middle of a button debounce
    button = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("r_valid", 32'(move_valid), 32'd0);
    chk("r_err",   32'(move_err),   32'd0);
    chk("r_cell",  32'(move_cell),  32'hF);
    chk("r_btn",   32'(btn_level),  32'd0);
    chk("r_sw",    32'(sw_level),   32'd0);
    rst = 1'b0;
    count_strobes(6, s);
    chk("r_quiet", 32'(s), 32'd0);
    tick(1);
    chk("r_strobe", 32'(move_err), 32'd1);
    button = 1'b0;
    tick(10);

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0) button = ~button;
      if ($urandom_range(0, 19) == 0) begin
        j = int'($urandom_range(0, 8));
        switches[j] = ~switches[j];
      end
      if ($urandom_range(0, 49) == 0) switches = 9'($urandom);
      rst = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/move_input_conditioner.md
Name: move_input_conditioner

Overview:
Upstream input stage for the game block. Takes the raw push-button and the 9 cell-select switches and synchronises and debounces each one. Each accepted button press produces exactly one single-cycle move request, carrying a cell index 0-8 or an error flag. The game block consumes move_valid/move_cell/move_err in place of the raw button/switches.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronised input must differ from its stable value before the change is accepted (20 ms at 50 MHz); legal range >= 2.
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  in  1  raw 50 MHz system clock
rst  in  1  synchronous, active-high reset
button  in  1  raw asynchronous push-button, 1 = pressed
switches  in  9  raw asynchronous cell-select switches; bit i selects cell i
move_valid  out  1  one-cycle strobe: legal move request, move_cell valid
move_err  out  1  one-cycle strobe: press with zero or more than one switch on
move_cell  out  4  cell index 0-8 of last request; 4'hF after error or reset
btn_level  out  1  debounced button level
sw_level  out  9  debounced switch levels

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). Both are decided.
- Reset values: move_valid=0, move_err=0, move_cell=4'hF, btn_level=0, sw_level=0. All synchroniser flops=0, all counters=0, FSM=IDLE.
- Synchroniser: each of the 10 inputs passes through 2 flops before any use. Raw inputs are never used combinationally.
- Debounce, per input, using synchronised value s, stable value q and counter c:
  - If s==q: c<=0.
  - Else if c==DEBOUNCE_CYCLES-1: q<=s and c<=0.
  - Else: c<=c+1.
  - A change is accepted only after s differs from q for DEBOUNCE_CYCLES consecutive cycles. Any single-cycle return to q restarts the count from 0.
  - Latency from a clean raw edge to the q change is 2+DEBOUNCE_CYCLES cycles.
- btn_level = q of button; sw_level = q of switches. Both are driven directly from the registers.
- Press FSM, 2 states:
  - IDLE: on the cycle btn_level is 1, evaluate sw_level. Next cycle, pulse move_valid or move_err for exactly 1 cycle, then go to HELD.
  - HELD: no strobes. Return to IDLE on the cycle btn_level is 0.
  - Result: one request per press. Holding the button never repeats. Switch changes while HELD are ignored.
- Evaluation of sw_level:
  - Exactly one bit i set: move_valid=1, move_cell<=i (4-bit binary).
  - Zero bits or two or more bits set: move_err=1, move_cell<=4'hF.
- move_valid and move_err are never high together. move_cell holds its value between strobes.
- Press-to-strobe latency: strobe is high in the cycle after the first cycle btn_level=1, so 3+DEBOUNCE_CYCLES cycles after a clean raw edge.
- Switches settling: sw_level is sampled at the press instant. Switches must be debounced-stable before the button is pressed, otherwise they are read at their old level.
- Reset mid-operation: rst during a debounce count, or while HELD, clears everything to reset values. No strobe is issued for the aborted press.
- Button held through reset: after rst deasserts the button re-debounces from q=0. One strobe is then produced; this is intended.

Test Plan (DEBOUNCE_CYCLES=4):
- Single legal move: switches=9'b000010000 held, then button raw 0->1 held -> exactly one move_valid pulse 7 cycles after the edge, move_cell=4, move_err=0, btn_level=1.
- Bounce rejection: button toggles 1,0,1,0,1 on consecutive cycles, then holds 1 -> btn_level rises only 4 cycles after the final 1 reaches the synchroniser output; exactly one strobe total.
- Error cases: switches=9'b0 and press -> move_err one cycle, move_cell=4'hF. Then switches=9'b100000001 and press -> move_err again, move_valid stays 0.
- Hold/re-press: switches=9'b1, button held 100 cycles -> one move_valid, move_cell=0. Release for >=6 cycles, set switches=9'b100000000, press again -> second move_valid with move_cell=8.
- Glitch reject: switch bit 3 pulses high for 3 cycles -> sw_level never changes; a subsequent press with all switches low -> move_err.
- Reset mid-debounce: button edge, rst asserted for 1 cycle 3 cycles later, button kept high -> no strobe around the reset. One strobe occurs 7 cycles after rst drops; all outputs read reset values during rst.
